// File: rtl/instr_queue_mi_pkg.sv
// instr_queue_mi_pkg: shared types and constants for the multi-issue instruction queue
package instr_queue_mi_pkg;
   localparam int INSTR_PER_FETCH = 4;
   localparam int FETCH_FIFO_DEPTH = 4;
   localparam logic [63:0] INSTR_PAGE_FAULT = 64'd12;
   typedef enum logic [2:0] {NO_CF, BRANCH, JUMP, JUMPR, RETURN} cf_t;
   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;
   typedef struct packed {
      cf_t         cf;
      logic [63:0] predict_address;
   } branchpredict_sbe_t;
   typedef struct packed {
      logic [63:0]        address;
      logic [31:0]        instruction;
      branchpredict_sbe_t branch_predict;
      exception_t         ex;
   } fetch_entry_t;
   // What a lane FIFO stores; cf is NO_CF unless the slot was the accepted taken slot
   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] addr;
      cf_t         cf;
      logic        ex;
   } instr_data_t;
endpackage

// File: rtl/instr_queue_mi_if.sv
// instr_queue_mi_if: fetch-side packet and decode-side issue ports of the instruction queue
//   slave  (queue):  takes instr/addr/valid/taken/cf_type/predict_address/exception/fetch_ack,
//                    drives replay/replay_addr/fetch_entry/fetch_valid
//   master (env):    the mirror image
interface instr_queue_mi_if #(
   parameter int NR_FETCH = 4,
   parameter int NR_ISSUE = 2
);
   import instr_queue_mi_pkg::*;
   logic [NR_FETCH-1:0][31:0] instr;
   logic [NR_FETCH-1:0][63:0] addr;
   logic [NR_FETCH-1:0]       valid;
   logic [NR_FETCH-1:0]       taken;
   cf_t  [NR_FETCH-1:0]       cf_type;
   logic [63:0]               predict_address;
   logic                      exception;
   logic                      replay;
   logic [63:0]               replay_addr;
   fetch_entry_t [NR_ISSUE-1:0] fetch_entry;
   logic [NR_ISSUE-1:0]       fetch_valid;
   logic [NR_ISSUE-1:0]       fetch_ack;
   modport slave (
      input  instr, addr, valid, taken, cf_type, predict_address, exception, fetch_ack,
      output replay, replay_addr, fetch_entry, fetch_valid
   );
   modport master (
      output instr, addr, valid, taken, cf_type, predict_address, exception, fetch_ack,
      input  replay, replay_addr, fetch_entry, fetch_valid
   );
endinterface

// File: rtl/instr_queue_mi_fifo.sv
// instr_queue_mi_fifo: small FIFO used for the lanes and the predict-address queue
//   clk_i, rst_ni: clock, async active-low reset; flush: sync clear
//   push/din, pop/dout: write and read side; full/empty: registered status
module instr_queue_mi_fifo #(
   parameter int  DEPTH = 4,
   parameter type T = logic
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic full,
   output logic empty
);
   localparam int PW = $clog2(DEPTH);
   T mem [DEPTH];
   logic [PW-1:0] rd_q, wr_q;
   logic [PW:0]   cnt_q;
   logic          do_push, do_pop;
   assign full = cnt_q == (PW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign dout = mem[rd_q];
   assign do_push = push & !full;
   assign do_pop = pop & !empty;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         if (do_pop) rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_q] <= din;
   end
   a_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full))
      else $error("fifo push while full");
endmodule

// File: rtl/instr_queue_mi_lane_select.sv
// instr_queue_mi_lane_select: compacts valid slots onto consecutive lanes starting at idx
//   idx: first free lane; mask: slots to place; accept: slots actually pushed (prefix of mask)
//   slot_lane: lane each slot maps to; lane_push/lane_data: per-lane write request and data
module instr_queue_mi_lane_select import instr_queue_mi_pkg::*; #(
   parameter int NR_FETCH = 4,
   localparam int IW = $clog2(NR_FETCH)
) (
   input  logic [IW-1:0]                idx,
   input  logic [NR_FETCH-1:0]          mask,
   input  logic [NR_FETCH-1:0]          accept,
   input  instr_data_t [NR_FETCH-1:0]   slot_data,
   output logic [NR_FETCH-1:0][IW-1:0]  slot_lane,
   output logic [NR_FETCH-1:0]          lane_push,
   output instr_data_t [NR_FETCH-1:0]   lane_data
);
   logic [IW-1:0] acc;
   // Lane of slot j = idx + number of masked slots below j, wrapping naturally in IW bits
   always_comb begin
      slot_lane = '0;
      acc = idx;
      for (int j = 0; j < NR_FETCH; j++) begin
         slot_lane[j] = acc;
         acc = acc + IW'(mask[j]);
      end
   end
   always_comb begin
      lane_push = '0;
      lane_data = '0;
      for (int j = 0; j < NR_FETCH; j++) begin
         if (accept[j]) begin
            lane_push[slot_lane[j]] = 1'b1;
            lane_data[slot_lane[j]] = slot_data[j];
         end
      end
   end
endmodule

// File: rtl/instr_queue_mi.sv
// instr_queue_mi: multi-issue instruction queue between fetch and decode
//   clk_i, rst_ni: clock, async active-low reset; flush_i: sync clear of all state
//   bus (slave): fetch packet in, replay request out, NR_ISSUE in-order entries out with ack
module instr_queue_mi import instr_queue_mi_pkg::*; #(
   parameter int NR_FETCH = INSTR_PER_FETCH,
   parameter int NR_ISSUE = 2,
   parameter int DEPTH = FETCH_FIFO_DEPTH,
   parameter int ADDR_DEPTH = 2
) (
   input logic clk_i,
   input logic rst_ni,
   input logic flush_i,
   instr_queue_mi_if.slave bus
);
   localparam int IW = $clog2(NR_FETCH);
   logic [IW-1:0] idx_is_q, idx_ds_q;
   logic [NR_FETCH-1:0] m, p, slot_taken, lane_full, lane_empty, lane_push, lane_pop;
   logic [NR_FETCH-1:0][IW-1:0] slot_lane;
   instr_data_t [NR_FETCH-1:0] slot_data, lane_din, lane_dout;
   logic [NR_ISSUE-1:0][IW-1:0] port_lane;
   fetch_entry_t [NR_ISSUE-1:0] entries;
   logic [NR_ISSUE-1:0] fv;
   logic addr_full, addr_empty, addr_push, addr_pop, seen, ok, open;
   logic [63:0] addr_head, replay_addr;
   instr_data_t ent;
   // Slots up to and including the first taken one; an exception packet keeps only slot 0
   always_comb begin
      m = '0;
      slot_taken = '0;
      slot_data = '0;
      seen = 1'b0;
      for (int j = 0; j < NR_FETCH; j++) begin
         m[j] = bus.valid[j] & !seen;
         seen = seen | bus.taken[j];
         slot_taken[j] = m[j] & bus.taken[j] & !bus.exception;
         slot_data[j].instr = bus.instr[j];
         slot_data[j].addr = bus.addr[j];
         slot_data[j].cf = (bus.taken[j] && !bus.exception) ? bus.cf_type[j] : NO_CF;
         slot_data[j].ex = bus.exception;
      end
      if (bus.exception) m = NR_FETCH'(1);
   end
   instr_queue_mi_lane_select #(.NR_FETCH(NR_FETCH)) u_lane_select (
      .idx(idx_is_q),
      .mask(m),
      .accept(p),
      .slot_data(slot_data),
      .slot_lane(slot_lane),
      .lane_push(lane_push),
      .lane_data(lane_din)
   );
   // Once one slot is refused every later slot is too, so p stays a prefix of m
   always_comb begin
      p = '0;
      ok = 1'b1;
      replay_addr = '0;
      for (int j = 0; j < NR_FETCH; j++) begin
         ok = ok & (!m[j] | (!lane_full[slot_lane[j]] & !(slot_taken[j] & addr_full)));
         p[j] = m[j] & ok;
      end
      for (int j = NR_FETCH - 1; j >= 0; j--) begin
         if (m[j] && !p[j]) replay_addr = bus.addr[j];
      end
   end
   assign bus.replay = p != m;
   assign bus.replay_addr = replay_addr;
   assign addr_push = |(p & slot_taken) & !flush_i;
   for (genvar i = 0; i < NR_FETCH; i++) begin : g_lane
      instr_queue_mi_fifo #(.DEPTH(DEPTH), .T(instr_data_t)) u_fifo (
         .clk_i(clk_i),
         .rst_ni(rst_ni),
         .flush(flush_i),
         .push(lane_push[i] & !flush_i),
         .din(lane_din[i]),
         .pop(lane_pop[i]),
         .dout(lane_dout[i]),
         .full(lane_full[i]),
         .empty(lane_empty[i])
      );
   end
   instr_queue_mi_fifo #(.DEPTH(ADDR_DEPTH), .T(logic [63:0])) u_addr_fifo (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .flush(flush_i),
      .push(addr_push),
      .din(bus.predict_address),
      .pop(addr_pop),
      .dout(addr_head),
      .full(addr_full),
      .empty(addr_empty)
   );
   // open drops after a taken entry so at most one visible entry owns the address FIFO head
   always_comb begin
      port_lane = '0;
      entries = '0;
      fv = '0;
      lane_pop = '0;
      addr_pop = 1'b0;
      ent = '0;
      open = 1'b1;
      for (int k = 0; k < NR_ISSUE; k++) begin
         port_lane[k] = idx_ds_q + IW'(k);
         ent = lane_dout[port_lane[k]];
         fv[k] = open & !lane_empty[port_lane[k]];
         open = fv[k] & (ent.cf == NO_CF);
         entries[k].address = ent.addr;
         entries[k].instruction = ent.instr;
         entries[k].branch_predict.cf = ent.cf;
         entries[k].branch_predict.predict_address = (ent.cf != NO_CF) ? addr_head : '0;
         entries[k].ex.valid = ent.ex;
         entries[k].ex.cause = ent.ex ? INSTR_PAGE_FAULT : '0;
         entries[k].ex.tval = ent.ex ? ent.addr : '0;
         lane_pop[port_lane[k]] = fv[k] & bus.fetch_ack[k] & !flush_i;
         addr_pop = addr_pop | (fv[k] & bus.fetch_ack[k] & (ent.cf != NO_CF) & !flush_i);
      end
   end
   assign bus.fetch_entry = entries;
   assign bus.fetch_valid = fv;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_is_q <= '0;
         idx_ds_q <= '0;
      end else if (flush_i) begin
         idx_is_q <= '0;
         idx_ds_q <= '0;
      end else begin
         idx_is_q <= idx_is_q + IW'($countones(p));
         idx_ds_q <= idx_ds_q + IW'($countones(bus.fetch_ack));
      end
   end
   a_ack_thermo: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.fetch_ack & (bus.fetch_ack + NR_ISSUE'(1))) == '0)
      else $error("fetch_ack not thermometer");
   a_ack_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.fetch_ack & ~fv) == '0)
      else $error("fetch_ack on invalid port");
   a_addr_pop: assert property (@(posedge clk_i) disable iff (!rst_ni) !(addr_pop && addr_empty))
      else $error("address fifo pop while empty");
endmodule

// File: tb/tb_instr_queue_mi.sv
// tb_instr_queue_mi: directed table plus random traffic against an in-order queue model
module tb_instr_queue_mi;
   import instr_queue_mi_pkg::*;
   localparam int NF = 4, NI = 2, DEPTH = 4, AD = 2;
   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   int n_vec = 0, n_err = 0;
   fetch_entry_t q[$];
   int ds = 0;
   typedef struct {
      logic [3:0] valid;
      logic [3:0] taken;
      bit         exc;
      bit         fl;
      int         ack;
      logic [1:0] fv;
      bit         rep;
      int         rslot;
   } vec_t;
   instr_queue_mi_if #(.NR_FETCH(NF), .NR_ISSUE(NI)) bus ();
   instr_queue_mi #(.NR_FETCH(NF), .NR_ISSUE(NI), .DEPTH(DEPTH), .ADDR_DEPTH(AD)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus)
   );
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int lane_cnt(input int l);
      int c = 0;
      foreach (q[i]) if ((ds + i) % NF == l) c++;
      return c;
   endfunction

   task automatic drive(input logic [3:0] valid, input logic [3:0] taken, input bit exc,
                        input bit fl, input logic [63:0] base);
      bus.valid = valid;
      bus.taken = taken;
      bus.exception = exc;
      flush = fl;
      bus.predict_address = base + 64'h1_0000;
      for (int j = 0; j < NF; j++) begin
         bus.addr[j] = base + 64'(4 * j);
         bus.instr[j] = $urandom;
         bus.cf_type[j] = cf_t'($urandom_range(1, 4));
      end
   endtask

   // Model: one in-order queue; entry i lives in lane (ds+i)%NF, taken entries use the address FIFO
   task automatic step(input int ack_req, input bit tab, input vec_t v);
      logic [NF-1:0] m;
      logic [NI-1:0] efv;
      int ft, rank, tk, n_ack;
      bit ok, erep, tj, prev;
      logic [63:0] eraddr;
      fetch_entry_t acc[$];
      fetch_entry_t e;
      efv = '0;
      prev = 1'b1;
      for (int k = 0; k < NI; k++) begin
         efv[k] = prev && k < q.size();
         prev = efv[k] && q[k].branch_predict.cf == NO_CF;
      end
      n_ack = ack_req > $countones(efv) ? $countones(efv) : ack_req;
      bus.fetch_ack = NI'((1 << n_ack) - 1);
      @(negedge clk);
      ft = NF;
      for (int j = NF - 1; j >= 0; j--) if (bus.taken[j]) ft = j;
      m = '0;
      for (int j = 0; j < NF; j++) m[j] = bus.valid[j] && j <= ft;
      if (bus.exception) m = 4'b0001;
      tk = 0;
      foreach (q[i]) if (q[i].branch_predict.cf != NO_CF) tk++;
      rank = 0;
      ok = 1'b1;
      erep = 1'b0;
      eraddr = '0;
      for (int j = 0; j < NF; j++) begin
         if (m[j]) begin
            tj = bus.taken[j] && !bus.exception;
            if (ok && lane_cnt((ds + q.size() + rank) % NF) < DEPTH && !(tj && tk >= AD)) begin
               e = '0;
               e.address = bus.addr[j];
               e.instruction = bus.instr[j];
               e.branch_predict.cf = tj ? bus.cf_type[j] : NO_CF;
               e.branch_predict.predict_address = tj ? bus.predict_address : 64'd0;
               e.ex.valid = bus.exception;
               e.ex.cause = bus.exception ? 64'd12 : 64'd0;
               e.ex.tval = bus.exception ? bus.addr[j] : 64'd0;
               acc.push_back(e);
            end else begin
               if (ok) eraddr = bus.addr[j];
               ok = 1'b0;
               erep = 1'b1;
            end
            rank++;
         end
      end
      check("replay", bus.replay, erep);
      if (erep) check("replay_addr", bus.replay_addr, eraddr);
      check("fetch_valid", bus.fetch_valid, efv);
      for (int k = 0; k < NI; k++)
         if (efv[k]) check($sformatf("entry%0d", k), bus.fetch_entry[k], q[k]);
      if (tab) begin
         check("tab_fetch_valid", bus.fetch_valid, v.fv);
         check("tab_replay", bus.replay, v.rep);
         if (v.rep) check("tab_replay_addr", bus.replay_addr, bus.addr[v.rslot]);
      end
      if (flush) begin
         q.delete();
         ds = 0;
      end else begin
         repeat (n_ack) void'(q.pop_front());
         ds = (ds + n_ack) % NF;
         foreach (acc[i]) q.push_back(acc[i]);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t tab[25];
      vec_t none;
      logic [3:0] t;
      none = '{4'b0, 4'b0, 1'b0, 1'b0, 0, 2'b0, 1'b0, 0};
      tab = '{
         '{4'b1111, 4'b0000, 1'b0, 1'b0, 0, 2'b00, 1'b0, 0},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 0, 2'b11, 1'b0, 0},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 2, 2'b11, 1'b0, 0},
         '{4'b1111, 4'b0100, 1'b0, 1'b0, 0, 2'b11, 1'b0, 0},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 2, 2'b11, 1'b0, 0},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 2, 2'b11, 1'b0, 0},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 1, 2'b01, 1'b0, 0},
         '{4'b0001, 4'b0001, 1'b0, 1'b0, 0, 2'b00, 1'b0, 0},
         '{4'b0001, 4'b0001, 1'b0, 1'b0, 0, 2'b01, 1'b0, 0},
         '{4'b1111, 4'b0001, 1'b0, 1'b0, 0, 2'b01, 1'b1, 0},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 1, 2'b01, 1'b0, 0},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 1, 2'b01, 1'b0, 0},
         '{4'b1111, 4'b0000, 1'b1, 1'b0, 0, 2'b00, 1'b0, 0},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 1, 2'b01, 1'b0, 0},
         '{4'b1111, 4'b0000, 1'b0, 1'b0, 0, 2'b00, 1'b0, 0},
         '{4'b1111, 4'b0000, 1'b0, 1'b0, 0, 2'b11, 1'b0, 0},
         '{4'b1111, 4'b0000, 1'b0, 1'b0, 0, 2'b11, 1'b0, 0},
         '{4'b0011, 4'b0000, 1'b0, 1'b0, 0, 2'b11, 1'b0, 0},
         '{4'b1111, 4'b0000, 1'b0, 1'b0, 0, 2'b11, 1'b1, 2},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 2, 2'b11, 1'b0, 0},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 2, 2'b11, 1'b0, 0},
         '{4'b1111, 4'b0000, 1'b0, 1'b1, 0, 2'b11, 1'b0, 0},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 0, 2'b00, 1'b0, 0},
         '{4'b1111, 4'b0000, 1'b0, 1'b0, 0, 2'b00, 1'b0, 0},
         '{4'b0000, 4'b0000, 1'b0, 1'b0, 0, 2'b11, 1'b0, 0}
      };
      bus.fetch_ack = '0;
      drive(4'b0, 4'b0, 1'b0, 1'b0, 64'h0);
      repeat (2) @(negedge clk);
      check("reset_fetch_valid", bus.fetch_valid, 2'b00);
      check("reset_replay", bus.replay, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 25; i++) begin
         drive(tab[i].valid, tab[i].taken, tab[i].exc, tab[i].fl, 64'h8000_0000 + 64'(i) * 64'h40);
         step(tab[i].ack, 1'b1, tab[i]);
      end
      for (int c = 0; c < 600; c++) begin
         t = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         drive(4'($urandom), t, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
               {$urandom, $urandom} & ~64'h3);
         step($urandom_range(0, 2), 1'b0, none);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
